// File: rtl/cardinal_ring_router.sv
// Three-port bidirectional ring router (CW, CCW, PE) with two polarity-alternated
// virtual channels and 1-deep buffers on every input and output port.
module cardinal_ring_router #(
  parameter int PACKET_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   polarity,
  input  logic                   cwsi,
  output logic                   cwri,
  input  logic [0:PACKET_SIZE-1] cwdi,
  input  logic                   ccwsi,
  output logic                   ccwri,
  input  logic [0:PACKET_SIZE-1] ccwdi,
  input  logic                   pesi,
  output logic                   peri,
  input  logic [0:PACKET_SIZE-1] pedi,
  output logic                   cwso,
  input  logic                   cwro,
  output logic [0:PACKET_SIZE-1] cwdo,
  output logic                   ccwso,
  input  logic                   ccwro,
  output logic [0:PACKET_SIZE-1] ccwdo,
  output logic                   peso,
  input  logic                   pero,
  output logic [0:PACKET_SIZE-1] pedo
);

  localparam int CW  = 0;
  localparam int CCW = 1;
  localparam int PE  = 2;

  typedef logic [0:PACKET_SIZE-1] pkt_t;

  logic       pol;
  logic       v;
  logic [1:0] in_full  [3];
  logic [1:0] out_full [3];
  pkt_t       in_buf   [3][2];
  pkt_t       out_buf  [3][2];
  pkt_t       hold     [3];
  logic [2:0] ptr;

  logic [2:0] si, ri, so, ro;
  pkt_t       di   [3];
  pkt_t       dout [3];
  pkt_t       mv   [3];
  logic [2:0] take, fill, flip;

  function automatic pkt_t dec_hop(input pkt_t p);
    pkt_t q;
    q = p;
    q[8:15] = p[8:15] - 8'd1;
    return q;
  endfunction

  // Returns {grant_b, grant_a}; ptr set means b is favoured on contention.
  function automatic logic [1:0] arb(input logic a, input logic b, input logic p,
                                     input logic free);
    logic [1:0] g;
    if (!free)
      g = 2'b00;
    else if (a && b)
      g = p ? 2'b10 : 2'b01;
    else
      g = {b, a};
    return g;
  endfunction

  assign polarity = pol;
  assign v        = ~pol;
  assign si       = {pesi, ccwsi, cwsi};
  assign ro       = {pero, ccwro, cwro};
  assign di[CW]   = cwdi;
  assign di[CCW]  = ccwdi;
  assign di[PE]   = pedi;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ri[i]   = ~reset & ~in_full[i][pol];
      so[i]   = ~reset & out_full[i][pol];
      dout[i] = '0;
      if (!reset)
        dout[i] = out_full[i][pol] ? out_buf[i][pol] : hold[i];
    end
  end

  assign cwri  = ri[CW];
  assign ccwri = ri[CCW];
  assign peri  = ri[PE];
  assign cwso  = so[CW];
  assign ccwso = so[CCW];
  assign peso  = so[PE];
  assign cwdo  = dout[CW];
  assign ccwdo = dout[CCW];
  assign pedo  = dout[PE];

  // Internal phase: route and arbitrate the VC opposite the current polarity
  logic cw_h0, ccw_h0, pe_dir;
  logic cw_to_cw, cw_to_pe, ccw_to_ccw, ccw_to_pe, pe_to_cw, pe_to_ccw;
  logic [1:0] g_cw, g_ccw, g_pe;

  assign cw_h0      = (in_buf[CW][v][8:15] == 8'd0);
  assign ccw_h0     = (in_buf[CCW][v][8:15] == 8'd0);
  assign pe_dir     = in_buf[PE][v][1];
  assign cw_to_cw   = in_full[CW][v] & ~cw_h0;
  assign cw_to_pe   = in_full[CW][v] & cw_h0;
  assign ccw_to_ccw = in_full[CCW][v] & ~ccw_h0;
  assign ccw_to_pe  = in_full[CCW][v] & ccw_h0;
  assign pe_to_cw   = in_full[PE][v] & ~pe_dir;
  assign pe_to_ccw  = in_full[PE][v] & pe_dir;

  assign g_cw  = arb(cw_to_cw, pe_to_cw, ptr[CW], ~out_full[CW][v]);
  assign g_ccw = arb(ccw_to_ccw, pe_to_ccw, ptr[CCW], ~out_full[CCW][v]);
  assign g_pe  = arb(cw_to_pe, ccw_to_pe, ptr[PE], ~out_full[PE][v]);

  assign take[CW]  = g_cw[0] | g_pe[0];
  assign take[CCW] = g_ccw[0] | g_pe[1];
  assign take[PE]  = g_cw[1] | g_ccw[1];
  assign fill      = {|g_pe, |g_ccw, |g_cw};
  assign flip[CW]  = cw_to_cw & pe_to_cw & ~out_full[CW][v];
  assign flip[CCW] = ccw_to_ccw & pe_to_ccw & ~out_full[CCW][v];
  assign flip[PE]  = cw_to_pe & ccw_to_pe & ~out_full[PE][v];

  assign mv[CW]  = g_cw[0]  ? dec_hop(in_buf[CW][v])  : in_buf[PE][v];
  assign mv[CCW] = g_ccw[0] ? dec_hop(in_buf[CCW][v]) : in_buf[PE][v];
  assign mv[PE]  = g_pe[0]  ? in_buf[CW][v]           : in_buf[CCW][v];

  // Control state: flags, pointers, polarity and the idle-output hold registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pol <= 1'b0;
      ptr <= '0;
      for (int i = 0; i < 3; i++) begin
        in_full[i]  <= '0;
        out_full[i] <= '0;
        hold[i]     <= '0;
      end
    end else begin
      pol <= ~pol;
      ptr <= ptr ^ flip;
      for (int i = 0; i < 3; i++) begin
        if (si[i] && ri[i]) in_full[i][pol]  <= 1'b1;
        if (take[i])        in_full[i][v]    <= 1'b0;
        if (so[i] && ro[i]) out_full[i][pol] <= 1'b0;
        if (fill[i])        out_full[i][v]   <= 1'b1;
        hold[i] <= dout[i];
      end
    end
  end

  // Packet storage: external writes use VC pol, internal moves use VC ~pol
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (si[i] && ri[i]) in_buf[i][pol] <= di[i];
      if (fill[i])        out_buf[i][v]  <= mv[i];
    end
  end

endmodule

// File: tb/tb_cardinal_ring_router.sv
// Directed bench for cardinal_ring_router: reset, injection, transit/ejection,
// backpressure, arbitration and mid-operation reset.
module tb_cardinal_ring_router;

  typedef logic [0:63] pkt_t;

  logic clk, reset, polarity;
  logic cwsi, cwri, ccwsi, ccwri, pesi, peri;
  logic cwso, cwro, ccwso, ccwro, peso, pero;
  pkt_t cwdi, ccwdi, pedi, cwdo, ccwdo, pedo;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  pkt_t pa, pb, pb0, a, b, c, x, y, x2, y2, r1, r2, r3, r4;

  cardinal_ring_router #(.PACKET_SIZE(64)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .cwsi(cwsi), .cwri(cwri), .cwdi(cwdi),
    .ccwsi(ccwsi), .ccwri(ccwri), .ccwdi(ccwdi),
    .pesi(pesi), .peri(peri), .pedi(pedi),
    .cwso(cwso), .cwro(cwro), .cwdo(cwdo),
    .ccwso(ccwso), .ccwro(ccwro), .ccwdo(ccwdo),
    .peso(peso), .pero(pero), .pedo(pedo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pkt_t mk(input logic vc, input logic dir, input logic [7:0] hop,
                              input logic [7:0] src, input logic [31:0] pay);
    pkt_t p;
    p        = '0;
    p[0]     = vc;
    p[1]     = dir;
    p[2:7]   = 6'b101101;
    p[8:15]  = hop;
    p[16:23] = src;
    p[24:31] = 8'h5C;
    p[32:63] = pay;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    cwsi = 0; ccwsi = 0; pesi = 0;
    cwro = 0; ccwro = 0; pero = 0;
    cwdi = '0; ccwdi = '0; pedi = '0;

    // reset held 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pol", polarity, 0);
    chk("rst_ri", {cwri, ccwri, peri}, 0);
    chk("rst_so", {cwso, ccwso, peso}, 0);
    chk("rst_cwdo", cwdo, 0);
    chk("rst_ccwdo", ccwdo, 0);
    chk("rst_pedo", pedo, 0);

    reset = 1'b0;
    #1;                                    // C0
    chk("c0_ri", {cwri, ccwri, peri}, 3'b111);
    chk("c0_pol", polarity, 0);
    tick;                                  // C1
    chk("c1_pol", polarity, 1);
    tick;                                  // C2
    chk("c2_pol", polarity, 0);

    // PE injection toward CW
    pa = mk(0, 0, 8'd2, 8'h05, 32'h1234);
    pedi = pa; pesi = 1; cwro = 1;
    tick;                                  // C3
    pesi = 0;
    chk("inj_early_cwso", cwso, 0);
    tick;                                  // C4
    chk("inj_cwso", cwso, 1);
    chk("inj_cwdo", cwdo, pa);
    tick;                                  // C5
    chk("inj_drained", cwso, 0);
    chk("inj_hold_cwdo", cwdo, pa);

    // Ring transit: hop 1 -> 0 on VC1
    pb  = mk(1, 0, 8'd1, 8'h07, 32'hBEEF);
    pb0 = mk(1, 0, 8'd0, 8'h07, 32'hBEEF);
    cwdi = pb; cwsi = 1;
    tick;                                  // C6
    cwsi = 0;
    tick;                                  // C7
    chk("transit_cwso", cwso, 1);
    chk("transit_cwdo", cwdo, pb0);
    cwdi = pb0; cwsi = 1; pero = 1;
    tick;                                  // C8
    cwsi = 0;
    chk("eject_early_peso", peso, 0);
    chk("transit_drained", cwso, 0);
    tick;                                  // C9
    chk("eject_peso", peso, 1);
    chk("eject_pedo", pedo, pb0);
    tick;                                  // C10

    // Backpressure on CW output, VC0
    cwro = 0;
    a = mk(0, 0, 8'd3, 8'h01, 32'h0000000A);
    b = mk(0, 0, 8'd3, 8'h01, 32'h0000000B);
    c = mk(0, 0, 8'd3, 8'h01, 32'h0000000C);
    cwdi = a; cwsi = 1;
    tick;                                  // C11
    cwsi = 0;
    tick;                                  // C12
    chk("bp_a_cwso", cwso, 1);
    chk("bp_a_cwdo", cwdo, mk(0, 0, 8'd2, 8'h01, 32'h0000000A));
    chk("bp_c12_cwri", cwri, 1);
    cwdi = b; cwsi = 1;
    tick;                                  // C13
    cwsi = 0;
    tick;                                  // C14
    chk("bp_hold_cwso", cwso, 1);
    chk("bp_hold_cwdo", cwdo, mk(0, 0, 8'd2, 8'h01, 32'h0000000A));
    chk("bp_c14_cwri", cwri, 0);
    cwdi = c; cwsi = 1;
    tick;                                  // C15
    cwsi = 0;
    tick;                                  // C16
    chk("bp_c16_cwri", cwri, 0);
    chk("bp_c16_cwdo", cwdo, mk(0, 0, 8'd2, 8'h01, 32'h0000000A));
    cwsi = 1; cwro = 1;
    tick;                                  // C17
    cwsi = 0;
    tick;                                  // C18
    chk("bp_b_cwso", cwso, 1);
    chk("bp_b_cwdo", cwdo, mk(0, 0, 8'd2, 8'h01, 32'h0000000B));
    chk("bp_c18_cwri", cwri, 1);
    cwsi = 1;
    tick;                                  // C19
    cwsi = 0;
    tick;                                  // C20
    chk("bp_c_cwso", cwso, 1);
    chk("bp_c_cwdo", cwdo, mk(0, 0, 8'd2, 8'h01, 32'h0000000C));
    tick;                                  // C21
    chk("bp_c21_cwso", cwso, 0);
    tick;                                  // C22
    chk("bp_nodup_cwso", cwso, 0);
    tick;                                  // C23

    // Arbitration for the PE output on VC1
    chk("arb_c23_pol", polarity, 1);
    x  = mk(1, 0, 8'd0, 8'h11, 32'h11111111);
    y  = mk(1, 1, 8'd0, 8'h22, 32'h22222222);
    x2 = mk(1, 0, 8'd0, 8'h33, 32'h33333333);
    y2 = mk(1, 1, 8'd0, 8'h44, 32'h44444444);
    cwdi = x; cwsi = 1; ccwdi = y; ccwsi = 1;
    tick;                                  // C24
    cwsi = 0; ccwsi = 0;
    tick;                                  // C25
    chk("arb1_peso", peso, 1);
    chk("arb1_first_cw", pedo, x);
    chk("arb1_ccw_waiting", ccwri, 0);
    tick;                                  // C26
    tick;                                  // C27
    chk("arb1_second_ccw", pedo, y);
    chk("arb1_ccwri", ccwri, 1);
    cwdi = x2; cwsi = 1; ccwdi = y2; ccwsi = 1;
    tick;                                  // C28
    cwsi = 0; ccwsi = 0;
    tick;                                  // C29
    chk("arb2_first_ccw", pedo, y2);
    tick;                                  // C30
    tick;                                  // C31
    chk("arb2_second_cw", pedo, x2);
    tick;                                  // C32

    // Fill four buffers, then reset mid-operation
    pero = 0; cwro = 0; ccwro = 0;
    r1 = mk(0, 0, 8'd2, 8'h51, 32'h00005151);
    r2 = mk(0, 1, 8'd2, 8'h52, 32'h00005252);
    r3 = mk(0, 0, 8'd5, 8'h53, 32'h00005353);
    r4 = mk(1, 0, 8'd2, 8'h54, 32'h00005454);
    cwdi = r1; cwsi = 1; ccwdi = r2; ccwsi = 1; pedi = r3; pesi = 1;
    tick;                                  // C33
    ccwsi = 0; pesi = 0;
    cwdi = r4; cwsi = 1;
    tick;                                  // C34
    cwsi = 0;
    chk("mid_cwso", cwso, 1);
    chk("mid_ccwdo", ccwdo, mk(0, 1, 8'd1, 8'h52, 32'h00005252));
    chk("mid_peri", peri, 0);
    reset = 1;
    #1;
    chk("mid_rst_so", {cwso, ccwso, peso}, 0);
    chk("mid_rst_ri", {cwri, ccwri, peri}, 0);
    chk("mid_rst_cwdo", cwdo, 0);
    @(posedge clk);
    #1;
    reset = 0;
    #1;
    chk("post_rst_pol", polarity, 0);
    chk("post_rst_ri", {cwri, ccwri, peri}, 3'b111);
    chk("post_rst_so", {cwso, ccwso, peso}, 0);
    cwro = 1; ccwro = 1; pero = 1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("post_rst_no_stale", {cwso, ccwso, peso}, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
